iob_t2p_asym_sync_ram: RTL and testbench

- Single-clock, two-port (one write, one read) RAM whose write and read ports have different, independently parametrised data widths.
- Either side may be the wider one; the ratio is a power of two.
- Adds configurable read latency, a read-valid flag and selectable read-during-write policy on top of a plain two-port memory.
- Used as the storage core for width-converting FIFOs and stream buffers.

---
 rtl/iob_t2p_asym_sync_ram_pkg.sv | 29 ++
 rtl/iob_ram_bank.sv | 24 ++
 rtl/iob_t2p_asym_sync_ram.sv | 118 +++++++++++
 tb/tb_iob_t2p_asym_sync_ram.sv | 127 ++++++++++++
 4 files changed

// File: rtl/iob_t2p_asym_sync_ram_pkg.sv
// iob_t2p_asym_sync_ram_pkg: shared sizing helpers and configuration check for the asymmetric RAM
package iob_t2p_asym_sync_ram_pkg;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int ratio_of(input int wd, input int rd);
        return max_i(wd, rd) / min_i(wd, rd);
    endfunction

    function automatic bit cfg_ok(input int wd, input int rd, input int wa, input int ra, input int lat);
        int mx = max_i(wd, rd);
        int mn = min_i(wd, rd);
        int rt = mx / mn;
        return (wd * (1 << wa) == rd * (1 << ra)) && (mx % mn == 0) && ((rt & (rt - 1)) == 0) && (lat == 1 || lat == 2);
    endfunction

endpackage

// File: rtl/iob_ram_bank.sv
// iob_ram_bank: simple dual-port synchronous bank, one write port and one registered read port
module iob_ram_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // storage write, never reset
    always_ff @(posedge clk) if (w_en) mem[w_addr] <= w_data;

    // registered read returns pre-write contents on a same-address collision
    always_ff @(posedge clk) r_data <= !rst_n ? '0 : r_en ? mem[r_addr] : r_data;

endmodule

// File: rtl/iob_t2p_asym_sync_ram.sv
// iob_t2p_asym_sync_ram: single-clock two-port RAM with independent write/read widths
module iob_t2p_asym_sync_ram
    import iob_t2p_asym_sync_ram_pkg::*;
#(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int W_ADDR_W = 4,
    parameter int R_ADDR_W = 6,
    parameter int R_LAT    = 1,
    parameter int FWD      = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                w_en,
    input  logic [W_ADDR_W-1:0] w_addr,
    input  logic [W_DATA_W-1:0] w_data,
    input  logic                r_en,
    input  logic [R_ADDR_W-1:0] r_addr,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_valid
);

    localparam int MIN_W       = min_i(W_DATA_W, R_DATA_W);
    localparam int MAX_W       = max_i(W_DATA_W, R_DATA_W);
    localparam int RATIO       = ratio_of(W_DATA_W, R_DATA_W);
    localparam int L           = clog2(RATIO);
    localparam int BANK_ADDR_W = min_i(W_ADDR_W, R_ADDR_W);

    if (!cfg_ok(W_DATA_W, R_DATA_W, W_ADDR_W, R_ADDR_W, R_LAT)) begin : g_cfg_err
        $fatal(1, "iob_t2p_asym_sync_ram: illegal width/depth/latency configuration");
    end

    logic [RATIO-1:0]       bank_we;
    logic [MAX_W-1:0]       bank_wd;
    logic [MAX_W-1:0]       bank_q;
    logic [BANK_ADDR_W-1:0] wrow;
    logic [BANK_ADDR_W-1:0] rrow;
    logic [R_DATA_W-1:0]    rd_mux;
    logic [R_DATA_W-1:0]    fm_n;
    logic [R_DATA_W-1:0]    fd_n;
    logic [R_DATA_W-1:0]    fm_q;
    logic [R_DATA_W-1:0]    fd_q;
    logic [R_DATA_W-1:0]    rd_merge;
    logic                   v1;

    for (genvar i = 0; i < RATIO; i++) begin : g_bank
        iob_ram_bank #(.DATA_W(MIN_W), .ADDR_W(BANK_ADDR_W)) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .w_en  (bank_we[i]),
            .w_addr(wrow),
            .w_data(bank_wd[i*MIN_W +: MIN_W]),
            .r_en  (r_en),
            .r_addr(rrow),
            .r_data(bank_q[i*MIN_W +: MIN_W])
        );
    end

    if (W_DATA_W == R_DATA_W) begin : g_eq
        assign bank_we = w_en;
        assign bank_wd = w_data;
        assign wrow    = w_addr;
        assign rrow    = r_addr;
        assign rd_mux  = bank_q;
        assign fm_n    = {R_DATA_W{w_en && w_addr == r_addr}};
        assign fd_n    = w_data;
    end else if (W_DATA_W > R_DATA_W) begin : g_wwide
        logic [L-1:0] lane_q;
        assign bank_we = {RATIO{w_en}};
        assign bank_wd = w_data;
        assign wrow    = w_addr;
        assign rrow    = r_addr[R_ADDR_W-1:L];
        assign rd_mux  = bank_q[lane_q*MIN_W +: MIN_W];
        assign fm_n    = {R_DATA_W{w_en && w_addr == rrow}};
        assign fd_n    = w_data[r_addr[L-1:0]*MIN_W +: MIN_W];
        // remember which narrow lane the pending read selects
        always_ff @(posedge clk) lane_q <= !rst_n ? '0 : r_en ? r_addr[L-1:0] : lane_q;
    end else begin : g_rwide
        // a narrow write touches only its own lane's bank
        always_comb begin
            bank_we = '0;
            bank_we[w_addr[L-1:0]] = w_en;
        end
        assign bank_wd = {RATIO{w_data}};
        assign wrow    = w_addr[W_ADDR_W-1:L];
        assign rrow    = r_addr;
        assign rd_mux  = bank_q;
        assign fm_n    = (w_en && wrow == r_addr) ? R_DATA_W'({MIN_W{1'b1}}) << (w_addr[L-1:0]*MIN_W) : '0;
        assign fd_n    = R_DATA_W'(w_data) << (w_addr[L-1:0]*MIN_W);
    end

    // capture write-through bits alongside each accepted read
    always_ff @(posedge clk) begin
        fm_q <= !rst_n ? '0 : r_en ? ((FWD != 0) ? fm_n : '0) : fm_q;
        fd_q <= !rst_n ? '0 : r_en ? fd_n : fd_q;
    end

    assign rd_merge = (rd_mux & ~fm_q) | (fd_q & fm_q);

    // first-stage valid tracks the bank read register
    always_ff @(posedge clk) v1 <= rst_n && r_en;

    if (R_LAT == 2) begin : g_lat2
        logic [R_DATA_W-1:0] d2;
        logic                v2;
        // optional output register stage
        always_ff @(posedge clk) begin
            v2 <= rst_n && v1;
            d2 <= !rst_n ? '0 : v1 ? rd_merge : d2;
        end
        assign r_data  = d2;
        assign r_valid = v2;
    end else begin : g_lat1
        assign r_data  = rd_merge;
        assign r_valid = v1;
    end

endmodule

// File: tb/tb_iob_t2p_asym_sync_ram.sv
// tb_iob_t2p_asym_sync_ram: directed self-checking bench for the asymmetric RAM
module tb_iob_t2p_asym_sync_ram;

    logic       clk = 0;
    logic       rst_n;
    logic       w_en;
    logic [3:0] w_addr;
    logic [31:0] w_data;
    logic       r_en;
    logic [5:0] r_addr;
    logic       w2_en;
    logic [5:0] w2_addr;
    logic [7:0] w2_data;
    logic       r2_en;
    logic [3:0] r2_addr;

    logic [7:0]  d0, d1, d3;
    logic        v0, v1, v3, v2;
    logic [31:0] d2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iob_t2p_asym_sync_ram u0 (.clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(d0), .r_valid(v0));
    iob_t2p_asym_sync_ram #(.FWD(1)) u1 (.clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(d1), .r_valid(v1));
    iob_t2p_asym_sync_ram #(.R_LAT(2)) u3 (.clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(d3), .r_valid(v3));
    iob_t2p_asym_sync_ram #(.W_DATA_W(8), .R_DATA_W(32), .W_ADDR_W(6), .R_ADDR_W(4)) u2 (.clk(clk), .rst_n(rst_n),
        .w_en(w2_en), .w_addr(w2_addr), .w_data(w2_data), .r_en(r2_en), .r_addr(r2_addr), .r_data(d2), .r_valid(v2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_b [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

    initial begin
        rst_n = 0; w_en = 0; w_addr = 0; w_data = 0; r_en = 0; r_addr = 0;
        w2_en = 0; w2_addr = 0; w2_data = 0; r2_en = 0; r2_addr = 0;
        step(); step();
        check("rst_v0", 32'(v0), 0);
        check("rst_d0", 32'(d0), 0);
        check("rst_v3", 32'(v3), 0);
        check("rst_d3", 32'(d3), 0);
        check("rst_v2", 32'(v2), 0);
        rst_n = 1;
        w_en = 1; w_addr = 0; w_data = 32'h44332211; step();
        w_addr = 1; w_data = 32'hDDCCBBAA; step();
        w_en = 0;
        for (int k = 0; k < 8; k++) begin
            r_en = 1; r_addr = 6'(k); step();
            check($sformatf("rd%0d_v0", k), 32'(v0), 1);
            check($sformatf("rd%0d_d0", k), 32'(d0), 32'(exp_b[k]));
            check($sformatf("rd%0d_d1", k), 32'(d1), 32'(exp_b[k]));
            check($sformatf("lat2_%0d_v", k), 32'(v3), (k >= 1) ? 1 : 0);
            if (k >= 1) check($sformatf("lat2_%0d_d", k), 32'(d3), 32'(exp_b[k-1]));
        end
        r_en = 0; step();
        check("tail_v0", 32'(v0), 0);
        check("tail_d0", 32'(d0), 32'hDD);
        check("tail_v3", 32'(v3), 1);
        check("tail_d3", 32'(d3), 32'hDD);
        step();
        check("tail2_v3", 32'(v3), 0);
        r_en = 1; r_addr = 2; step();
        r_en = 0;
        check("idle_rd_d0", 32'(d0), 32'h33);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("idle%0d_d0", k), 32'(d0), 32'h33);
            check($sformatf("idle%0d_v0", k), 32'(v0), 0);
        end
        w_en = 1; w_addr = 0; w_data = 32'h88776655; r_en = 1; r_addr = 1; step();
        w_en = 0;
        check("coll_d0", 32'(d0), 32'h22);
        check("coll_d1", 32'(d1), 32'h66);
        check("coll_v1", 32'(v1), 1);
        step();
        r_en = 0;
        check("after_d0", 32'(d0), 32'h66);
        check("after_d1", 32'(d1), 32'h66);
        check("coll_d3", 32'(d3), 32'h22);
        step();
        r_en = 1; r_addr = 0; step();
        check("mid_v3_pre", 32'(v3), 0);
        r_en = 0; rst_n = 0; w_en = 1; w_addr = 2; w_data = 32'h0A0B0C0D; step();
        check("mid_rst_v3", 32'(v3), 0);
        check("mid_rst_d3", 32'(d3), 0);
        check("mid_rst_d0", 32'(d0), 0);
        rst_n = 1; w_en = 0; step();
        check("mid_post_v3", 32'(v3), 0);
        check("mid_post_v0", 32'(v0), 0);
        r_en = 1; r_addr = 8; step();
        r_en = 0;
        check("rstwr_d0", 32'(d0), 32'h0D);
        step();
        check("rstwr_v3", 32'(v3), 1);
        check("rstwr_d3", 32'(d3), 32'h0D);
        w2_en = 1;
        for (int k = 0; k < 4; k++) begin
            w2_addr = 6'(4 + k); w2_data = exp_b[4+k]; step();
        end
        w2_en = 0; r2_en = 1; r2_addr = 1; step();
        r2_en = 0;
        check("rev_v2", 32'(v2), 1);
        check("rev_d2", d2, 32'hDDCCBBAA);
        step();
        check("rev_hold_v2", 32'(v2), 0);
        check("rev_hold_d2", d2, 32'hDDCCBBAA);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
